// File: rtl/mem_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_stage_pkg
//   Shared definitions for the memory stage:
//     - FSM state encoding for two-cycle (32-bit) stack transfers
//     - stack-pointer update operations driven into sp_unit
//     - bit positions of the memory controls inside the 6-bit Mem field
//     - default address width and stack-pointer reset value
// ---------------------------------------------------------------------------
package mem_stage_pkg;

    localparam int unsigned DEF_ADDR_W  = 20;

    // Mem field layout: {valid, wide, pop, push, write, read}
    localparam int unsigned MEM_FIELD_W = 6;
    localparam int unsigned MB_READ     = 0;
    localparam int unsigned MB_WRITE    = 1;
    localparam int unsigned MB_PUSH     = 2;
    localparam int unsigned MB_POP      = 3;
    localparam int unsigned MB_WIDE     = 4;
    localparam int unsigned MB_VALID    = 5;

    typedef enum logic {
        IDLE,
        WIDE2
    } state_t;

    typedef enum logic [2:0] {
        SP_HOLD,
        SP_INC1,
        SP_INC2,
        SP_DEC1,
        SP_DEC2
    } sp_op_t;

    // Empty-stack value: the top word of the address space.
    function automatic logic [31:0] sp_init_default(input int unsigned addr_w);
        return (32'd1 << addr_w) - 32'd1;
    endfunction

endpackage

// File: rtl/mem_stage_sp.sv
// ---------------------------------------------------------------------------
// sp_unit
//   Stack-pointer register with its neighbour values and empty-stack checks.
//   Ports:
//     clk, rst            clock, asynchronous active-low reset (SP <= SP_INIT)
//     op                  update applied at the next rising edge
//     sp                  current stack pointer
//     sp_p1, sp_p2, sp_m1 SP+1, SP+2, SP-1 (modulo 2^ADDR_W)
//     empty1, empty2      a 1-word / 2-word pop would read above SP_INIT
// ---------------------------------------------------------------------------
module sp_unit
    import mem_stage_pkg::*;
#(
    parameter int unsigned        ADDR_W  = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0]  SP_INIT = ADDR_W'(sp_init_default(ADDR_W))
) (
    input  logic              clk,
    input  logic              rst,
    input  sp_op_t            op,
    output logic [ADDR_W-1:0] sp,
    output logic [ADDR_W-1:0] sp_p1,
    output logic [ADDR_W-1:0] sp_p2,
    output logic [ADDR_W-1:0] sp_m1,
    output logic              empty1,
    output logic              empty2
);

    logic [ADDR_W:0] ext_p1;
    logic [ADDR_W:0] ext_p2;
    logic [ADDR_W:0] ext_init;

    assign sp_p1 = sp + ADDR_W'(1);
    assign sp_p2 = sp + ADDR_W'(2);
    assign sp_m1 = sp - ADDR_W'(1);

    // Empty check uses one extra bit so SP+n is compared without wrapping.
    assign ext_p1   = {1'b0, sp} + (ADDR_W + 1)'(1);
    assign ext_p2   = {1'b0, sp} + (ADDR_W + 1)'(2);
    assign ext_init = {1'b0, SP_INIT};
    assign empty1   = (ext_p1 > ext_init);
    assign empty2   = (ext_p2 > ext_init);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp <= SP_INIT;
        end else begin
            case (op)
                SP_INC1: sp <= sp_p1;
                SP_INC2: sp <= sp_p2;
                SP_DEC1: sp <= sp_m1;
                SP_DEC2: sp <= sp - ADDR_W'(2);
                default: sp <= sp;
            endcase
        end
    end

endmodule

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
//   Memory pipeline stage: 16-bit loads/stores, 16-bit PUSH/POP and 32-bit
//   PC push/pop (two cycles, first cycle stalls upstream). Owns the SP.
//   Ports:
//     clk, rst             clock, asynchronous active-low reset
//     i_valid              instruction present upstream
//     i_mem_read/write     load / store at i_alu
//     i_push/i_pop/i_wide  stack ops; i_wide selects 32-bit PC transfer
//     i_wb, i_rdst, i_alu  pass-through fields (i_alu is also the address)
//     i_wdata, i_pc        store/push data, PC to push
//     mem_addr/wdata/we    single-port data memory (async read, sync write)
//     mem_rdata            data-memory read data
//     o_stall              combinational upstream freeze
//     o_valid..o_fault     registered results; o_sp is the live SP
// ---------------------------------------------------------------------------
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned        ADDR_W  = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0]  SP_INIT = ADDR_W'(sp_init_default(ADDR_W))
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic              i_wide,
    input  logic [3:0]        i_wb,
    input  logic [2:0]        i_rdst,
    input  logic [15:0]       i_alu,
    input  logic [15:0]       i_wdata,
    input  logic [31:0]       i_pc,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              mem_we,
    input  logic [15:0]       mem_rdata,
    output logic              o_stall,
    output logic              o_valid,
    output logic [3:0]        o_wb,
    output logic [2:0]        o_rdst,
    output logic [15:0]       o_alu,
    output logic [15:0]       o_rdata,
    output logic              o_pc_load,
    output logic [31:0]       o_ret_pc,
    output logic [ADDR_W-1:0] o_sp,
    output logic              o_fault
);

    state_t                 state;
    logic                   wide_pop;
    logic [15:0]            pop_lo;

    logic [MEM_FIELD_W-1:0] mem_field;
    logic                   op_valid;
    logic                   op_rd;
    logic                   op_wr;
    logic                   op_push;
    logic                   op_pop;
    logic                   op_wide;

    sp_op_t                 sp_op;
    logic [ADDR_W-1:0]      sp_p1;
    logic [ADDR_W-1:0]      sp_p2;
    logic [ADDR_W-1:0]      sp_m1;
    logic                   empty1;
    logic                   empty2;

    logic                   pop_fault;
    logic                   start_wide;
    logic                   we;

    sp_unit #(
        .ADDR_W  (ADDR_W),
        .SP_INIT (SP_INIT)
    ) u_sp (
        .clk    (clk),
        .rst    (rst),
        .op     (sp_op),
        .sp     (o_sp),
        .sp_p1  (sp_p1),
        .sp_p2  (sp_p2),
        .sp_m1  (sp_m1),
        .empty1 (empty1),
        .empty2 (empty2)
    );

    always_comb begin
        mem_field            = '0;
        mem_field[MB_READ]   = i_mem_read;
        mem_field[MB_WRITE]  = i_mem_write;
        mem_field[MB_PUSH]   = i_push;
        mem_field[MB_POP]    = i_pop;
        mem_field[MB_WIDE]   = i_wide;
        mem_field[MB_VALID]  = i_valid;
    end

    assign op_valid = mem_field[MB_VALID];
    assign op_rd    = mem_field[MB_READ];
    assign op_wr    = mem_field[MB_WRITE];
    assign op_push  = mem_field[MB_PUSH];
    assign op_pop   = mem_field[MB_POP];
    assign op_wide  = mem_field[MB_WIDE];

    // Memory-side decode. In WIDE2 the upstream inputs are still held by the
    // stall, so i_pc is reused for the low half; direction comes from wide_pop.
    always_comb begin
        pop_fault  = (state == IDLE) && op_valid && op_pop && (op_wide ? empty2 : empty1);
        start_wide = (state == IDLE) && op_valid && op_wide &&
                     (op_push || (op_pop && !pop_fault));
        mem_addr   = ADDR_W'(i_alu);
        mem_wdata  = i_wdata;
        we         = 1'b0;
        sp_op      = SP_HOLD;
        if (state == WIDE2) begin
            if (wide_pop) begin
                mem_addr = sp_p2;
                sp_op    = SP_INC2;
            end else begin
                mem_addr  = sp_m1;
                mem_wdata = i_pc[15:0];
                we        = 1'b1;
                sp_op     = SP_DEC2;
            end
        end else if (op_valid) begin
            if (op_push) begin
                mem_addr = o_sp;
                we       = 1'b1;
                if (op_wide) begin
                    mem_wdata = i_pc[31:16];
                end else begin
                    sp_op = SP_DEC1;
                end
            end else if (op_pop) begin
                mem_addr = sp_p1;
                if (!op_wide && !pop_fault) begin
                    sp_op = SP_INC1;
                end
            end else if (op_wr) begin
                we = 1'b1;
            end
        end
    end

    // Gated by reset so nothing is written or stalled while rst is held low.
    assign mem_we  = we & rst;
    assign o_stall = start_wide & rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            wide_pop  <= 1'b0;
            pop_lo    <= '0;
            o_valid   <= 1'b0;
            o_wb      <= '0;
            o_rdst    <= '0;
            o_alu     <= '0;
            o_rdata   <= '0;
            o_pc_load <= 1'b0;
            o_ret_pc  <= '0;
            o_fault   <= 1'b0;
        end else begin
            o_valid   <= 1'b0;
            o_wb      <= '0;
            o_rdst    <= '0;
            o_alu     <= '0;
            o_rdata   <= '0;
            o_pc_load <= 1'b0;
            o_ret_pc  <= '0;
            o_fault   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_wide) begin
                        state    <= WIDE2;
                        wide_pop <= op_pop;
                        pop_lo   <= mem_rdata;
                    end else if (op_valid) begin
                        o_valid <= 1'b1;
                        o_wb    <= i_wb;
                        o_rdst  <= i_rdst;
                        o_alu   <= i_alu;
                        o_fault <= pop_fault;
                        if ((op_rd || op_pop) && !pop_fault) begin
                            o_rdata <= mem_rdata;
                        end
                    end
                end
                WIDE2: begin
                    state   <= IDLE;
                    o_valid <= 1'b1;
                    o_wb    <= i_wb;
                    o_rdst  <= i_rdst;
                    o_alu   <= i_alu;
                    if (wide_pop) begin
                        o_pc_load <= 1'b1;
                        o_ret_pc  <= {mem_rdata, pop_lo};
                    end
                end
            endcase
        end
    end

endmodule
